// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of a synchronous FIFO write port.
// A burst is granted only when the FIFO already has room for every beat of it.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned REQ_PTR    = 2,
  parameter int unsigned FIFO_PTR   = 4,
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                               fifo_clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*(FIFO_PTR+1)-1:0]    req_len,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]      req_data,
  input  logic [FIFO_PTR:0]                  fifo_room_avail,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic [NUM_REQ-1:0]                 gnt_beat,
  output logic [NUM_REQ-1:0]                 burst_done,
  output logic                               fifo_wren,
  output logic [FIFO_WIDTH-1:0]              fifo_wrdata,
  output logic                               busy
);

  localparam int unsigned LEN_W = FIFO_PTR + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [REQ_PTR-1:0]        rr_ptr_q, rr_ptr_d;
  logic [REQ_PTR-1:0]        sel_q, sel_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d;

  logic [NUM_REQ-1:0][LEN_W-1:0] len_eff;
  logic                          win_found;
  logic [REQ_PTR-1:0]            win_idx;
  logic                          sel_valid;

  // Zero-length requests mean one beat; longer than the FIFO is clamped to its depth.
  always_comb begin : len_clamp
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      len_eff[i] = req_len[i*LEN_W +: LEN_W];
      if (len_eff[i] == '0) begin
        len_eff[i] = LEN_W'(1);
      end else if (len_eff[i] > LEN_W'(FIFO_DEPTH)) begin
        len_eff[i] = LEN_W'(FIFO_DEPTH);
      end
    end
  end

  // First active request at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin : rr_search
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!win_found && req[REQ_PTR'(idx)]) begin
        win_found = 1'b1;
        win_idx   = REQ_PTR'(idx);
      end
    end
  end

  always_comb begin : fsm_comb
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    gnt_beat    = '0;
    burst_done  = '0;
    fifo_wren   = 1'b0;
    fifo_wrdata = '0;
    sel_valid   = req_valid[sel_q];

    case (state_q)
      ST_IDLE: begin
        // No fallback to a smaller request when the winner does not fit: prevents starvation.
        if (win_found && (len_eff[win_idx] <= fifo_room_avail)) begin
          state_d  = ST_BURST;
          gnt_d    = NUM_REQ'(1) << win_idx;
          sel_d    = win_idx;
          cnt_d    = len_eff[win_idx];
          rr_ptr_d = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + REQ_PTR'(1);
        end
      end
      ST_BURST: begin
        fifo_wren       = sel_valid;
        fifo_wrdata     = req_data[32'(sel_q)*FIFO_WIDTH +: FIFO_WIDTH];
        gnt_beat[sel_q] = sel_valid;
        if (sel_valid) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            burst_done[sel_q] = 1'b1;
            state_d           = ST_IDLE;
            gnt_d             = '0;
          end
        end else if (!req[sel_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge fifo_clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == ST_BURST);

endmodule
